// File: rtl/vec_seq_pkg.sv
// Shared state encoding, MISR constants and default widths for the vector sequencer.
package vec_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

  localparam logic [31:0] MISR_POLY = 32'h04C1_1DB7;
  localparam logic [31:0] MISR_SEED = 32'hFFFF_FFFF;

  localparam int DEF_VEC_W = 256;
  localparam int DEF_Y_W   = 350;
  localparam int DEF_DEPTH = 8;
  localparam int DEF_LAT   = 1;

  // Wide enough to count the longest drain (LAT up to 4).
  localparam int DRAIN_CNT_W = 3;

  function automatic logic [31:0] misr_step(input logic [31:0] sig_cur,
                                            input logic [31:0] fold_in);
    return {sig_cur[30:0], 1'b0} ^ (sig_cur[31] ? MISR_POLY : 32'h0) ^ fold_in;
  endfunction

endpackage

// File: rtl/vec_fifo.sv
// Vector FIFO: DEPTH entries of W bits, show-ahead head, synchronous flush.
module vec_fifo
  import vec_seq_pkg::*;
#(
  parameter int W     = DEF_VEC_W,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head    = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/vec_sequencer.sv
// Plays queued vectors into a DUT one per cycle and compacts the DUT response
// into a 32-bit MISR signature.
module vec_sequencer
  import vec_seq_pkg::*;
#(
  parameter int VEC_W = DEF_VEC_W,
  parameter int Y_W   = DEF_Y_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int LAT   = DEF_LAT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [VEC_W-1:0] ld_data,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [VEC_W-1:0] dut_in,
  input  logic [Y_W-1:0]   dut_y,
  output logic [31:0]      sig,
  output logic [15:0]      vec_cnt
);

  localparam int NSLICE = (Y_W + 31) / 32;

  seq_state_e              state_q;
  seq_state_e              state_d;
  logic [DRAIN_CNT_W-1:0]  drain_cnt_q;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [VEC_W-1:0]        fifo_head;
  logic                    push;
  logic                    pop;
  logic                    abort_act;
  logic                    run_go;
  logic                    capture;
  logic [VEC_W-1:0]        dut_in_q;
  logic [LAT-1:0]          vld_q;
  logic [LAT-1:0]          vld_d;
  logic [31:0]             sig_q;
  logic [15:0]             vec_cnt_q;
  logic [NSLICE*32-1:0]    y_pad;
  logic [31:0]             fold_acc [NSLICE+1];
  logic [31:0]             fold;

  // Abort only matters while playing; it also blocks a same-cycle load.
  assign abort_act = abort && ((state_q == ST_RUN) || (state_q == ST_DRAIN));
  assign ld_ready  = !fifo_full && !abort_act;
  assign push      = ld_valid && ld_ready;
  assign pop       = (state_q == ST_RUN) && !fifo_empty && !abort_act;
  assign run_go    = (state_q == ST_IDLE) && start && !fifo_empty;

  vec_fifo #(
    .W     (VEC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (abort_act),
    .push      (push),
    .push_data (ld_data),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (run_go) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (abort_act)       state_d = ST_DONE;
        else if (fifo_empty) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (abort_act)                                     state_d = ST_DONE;
        else if (drain_cnt_q == DRAIN_CNT_W'(LAT - 1))     state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      ST_RUN, ST_DRAIN: busy = 1'b1;
      ST_DONE:          done = 1'b1;
      default:          ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n || (state_q != ST_DRAIN)) begin
      drain_cnt_q <= '0;
    end else begin
      drain_cnt_q <= drain_cnt_q + 1'b1;
    end
  end

  // Valid bit travels alongside each driven vector until its response is due.
  genvar gi;
  assign vld_d[0] = pop;
  generate
    for (gi = 1; gi < LAT; gi++) begin : g_vld
      assign vld_d[gi] = vld_q[gi-1];
    end
  endgenerate

  assign capture = vld_q[LAT-1] && !abort_act;

  always_comb begin
    y_pad          = '0;
    y_pad[Y_W-1:0] = dut_y;
  end

  assign fold_acc[0] = 32'h0;
  generate
    for (gi = 0; gi < NSLICE; gi++) begin : g_fold
      assign fold_acc[gi+1] = fold_acc[gi] ^ y_pad[gi*32 +: 32];
    end
  endgenerate
  assign fold = fold_acc[NSLICE];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dut_in_q  <= '0;
      vld_q     <= '0;
      sig_q     <= '0;
      vec_cnt_q <= '0;
    end else begin
      dut_in_q <= pop ? fifo_head : '0;
      vld_q    <= abort_act ? '0 : vld_d;
      if (run_go) begin
        sig_q     <= MISR_SEED;
        vec_cnt_q <= '0;
      end else begin
        if (capture) begin
          sig_q <= misr_step(sig_q, fold);
        end
        if (pop && (vec_cnt_q != 16'hFFFF)) begin
          vec_cnt_q <= vec_cnt_q + 16'd1;
        end
      end
    end
  end

  assign dut_in  = dut_in_q;
  assign sig     = sig_q;
  assign vec_cnt = vec_cnt_q;

endmodule

// File: tb/tb_vec_sequencer.sv
// Directed bench for vec_sequencer with a combinational (LAT=1) DUT model.
module tb_vec_sequencer;

  localparam int VEC_W = 256;
  localparam int Y_W   = 350;
  localparam int DEPTH = 8;
  localparam int LAT   = 1;
  localparam logic [31:0] POLY = 32'h04C11DB7;
  localparam logic [31:0] SEED = 32'hFFFFFFFF;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             ld_valid = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [VEC_W-1:0] ld_data = '0;
  logic             ld_ready;
  logic             busy;
  logic             done;
  logic [VEC_W-1:0] dut_in;
  logic [Y_W-1:0]   dut_y;
  logic [31:0]      sig;
  logic [15:0]      vec_cnt;

  int n_checks   = 0;
  int n_pass     = 0;
  int done_seen  = 0;

  always #5 clk = ~clk;

  vec_sequencer #(
    .VEC_W (VEC_W),
    .Y_W   (Y_W),
    .DEPTH (DEPTH),
    .LAT   (LAT)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ld_valid (ld_valid),
    .ld_ready (ld_ready),
    .ld_data  (ld_data),
    .start    (start),
    .abort    (abort),
    .busy     (busy),
    .done     (done),
    .dut_in   (dut_in),
    .dut_y    (dut_y),
    .sig      (sig),
    .vec_cnt  (vec_cnt)
  );

  function automatic logic [Y_W-1:0] y_of(input logic [VEC_W-1:0] v);
    return {v[101:8], v};
  endfunction

  assign dut_y = y_of(dut_in);

  always @(negedge clk) begin
    if (done) done_seen++;
  end

  function automatic logic [VEC_W-1:0] pat(input int i);
    logic [VEC_W-1:0] p;
    for (int w = 0; w < VEC_W / 32; w++) begin
      p[w*32 +: 32] = 32'(32'h9E3779B9 * (i + 1)) ^ 32'(32'h01010101 * w) ^ 32'h5A5A0000;
    end
    return p;
  endfunction

  function automatic logic [31:0] fold_ref(input logic [Y_W-1:0] y);
    logic [31:0] f;
    f = '0;
    for (int b = 0; b < Y_W; b++) f[b % 32] = f[b % 32] ^ y[b];
    return f;
  endfunction

  function automatic logic [31:0] misr_ref(input logic [31:0] s, input logic [31:0] f);
    logic [31:0] n;
    n = s << 1;
    if (s[31]) n = n ^ POLY;
    return n ^ f;
  endfunction

  function automatic logic [31:0] sig_of(input int first, input int n);
    logic [31:0] s;
    s = SEED;
    for (int i = 0; i < n; i++) s = misr_ref(s, fold_ref(y_of(pat(first + i))));
    return s;
  endfunction

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [VEC_W-1:0] v);
    ld_valid = 1'b1;
    ld_data  = v;
    step();
    ld_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Cycle 0 is the cycle start was high; returns -1 if done never shows.
  task automatic wait_done(input int cyc0, output int done_at);
    int cyc;
    cyc     = cyc0;
    done_at = -1;
    for (int k = 0; k < 40; k++) begin
      if (done) begin
        done_at = cyc;
        break;
      end
      step();
      cyc++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int d0;
    int done_at;

    repeat (2) step();
    check_eq("rst_busy",     busy,     0);
    check_eq("rst_done",     done,     0);
    check_eq("rst_ld_ready", ld_ready, 1);
    check_eq("rst_sig",      sig,      0);
    check_eq("rst_vec_cnt",  vec_cnt,  0);
    check_eq("rst_dut_in",   dut_in,   0);
    rst_n = 1'b1;
    step();

    // Single all-zero vector, y = 0.
    load('0);
    do_start();
    check_eq("t1_busy_run", busy, 1);
    step();
    check_eq("t1_vec_cnt_c2", vec_cnt, 1);
    wait_done(2, done_at);
    check_eq("t1_done_cycle", done_at, 3 + LAT);
    check_eq("t1_sig",        sig,     32'hFB3EE249);
    check_eq("t1_vec_cnt",    vec_cnt, 1);
    $display("run zero-vector: done_at=%0d vec_cnt=%0d sig=%08h", done_at, vec_cnt, sig);
    step();
    check_eq("t1_done_pulse_end", done, 0);
    check_eq("t1_idle_busy",      busy, 0);
    check_eq("t1_sig_retained",   sig,  32'hFB3EE249);

    // Start with an empty FIFO is ignored.
    d0 = done_seen;
    do_start();
    check_eq("t2_busy", busy, 0);
    repeat (4) step();
    check_eq("t2_no_done",       done_seen, d0);
    check_eq("t2_vec_cnt_kept",  vec_cnt,   1);
    $display("start on empty fifo: busy=%0d", busy);

    // Fill to DEPTH, 9th load refused, then play all eight.
    for (int i = 0; i < 8; i++) load(pat(i));
    check_eq("t3_full_ready", ld_ready, 0);
    ld_valid = 1'b1;
    ld_data  = pat(99);
    step();
    ld_valid = 1'b0;
    check_eq("t3_still_full", ld_ready, 0);
    do_start();
    for (int j = 0; j < 8; j++) begin
      step();
      check_eq($sformatf("t3_play%0d", j), dut_in, pat(j));
    end
    step();
    check_eq("t3_dut_in_idle", dut_in, 0);
    wait_done(10, done_at);
    check_eq("t3_done_cycle", done_at, 8 + 2 + LAT);
    check_eq("t3_vec_cnt",    vec_cnt, 8);
    check_eq("t3_sig",        sig,     sig_of(0, 8));
    $display("run fill-8: done_at=%0d vec_cnt=%0d sig=%08h", done_at, vec_cnt, sig);
    step();

    // Loads streaming in while RUN pops every cycle.
    load(pat(20));
    load(pat(21));
    for (int k = 0; k < 10; k++) begin
      ld_valid = 1'b1;
      ld_data  = pat(22 + k);
      start    = (k == 0);
      step();
      start = 1'b0;
      if (k >= 1) check_eq($sformatf("t4_play%0d", 19 + k), dut_in, pat(19 + k));
    end
    ld_valid = 1'b0;
    for (int idx = 29; idx <= 31; idx++) begin
      step();
      check_eq($sformatf("t4_play%0d", idx), dut_in, pat(idx));
    end
    wait_done(13, done_at);
    check_eq("t4_done_cycle", done_at, 12 + 2 + LAT);
    check_eq("t4_vec_cnt",    vec_cnt, 12);
    check_eq("t4_sig",        sig,     sig_of(20, 12));
    $display("run stream-12: done_at=%0d vec_cnt=%0d sig=%08h", done_at, vec_cnt, sig);
    step();

    // Abort while the third vector is on dut_in, with start and load also asserted.
    for (int i = 0; i < 8; i++) load(pat(40 + i));
    do_start();
    repeat (3) step();
    check_eq("t5_pre_cnt",    vec_cnt, 3);
    check_eq("t5_pre_dut_in", dut_in,  pat(42));
    abort    = 1'b1;
    start    = 1'b1;
    ld_valid = 1'b1;
    ld_data  = pat(77);
    #1;
    check_eq("t5_ready_abort", ld_ready, 0);
    step();
    abort    = 1'b0;
    start    = 1'b0;
    ld_valid = 1'b0;
    check_eq("t5_done",     done,     1);
    check_eq("t5_vec_cnt",  vec_cnt,  3);
    check_eq("t5_dut_in",   dut_in,   0);
    check_eq("t5_sig_held", sig,      sig_of(40, 2));
    check_eq("t5_ready",    ld_ready, 1);
    $display("run abort: vec_cnt=%0d sig=%08h", vec_cnt, sig);
    step();
    do_start();
    check_eq("t5_fifo_empty", busy, 0);
    step();

    // Reset in the middle of RUN.
    for (int i = 0; i < 4; i++) load(pat(60 + i));
    do_start();
    repeat (2) step();
    check_eq("t6_busy_pre", busy, 1);
    d0    = done_seen;
    rst_n = 1'b0;
    step();
    check_eq("t6_busy",     busy,     0);
    check_eq("t6_done",     done,     0);
    check_eq("t6_dut_in",   dut_in,   0);
    check_eq("t6_sig",      sig,      0);
    check_eq("t6_vec_cnt",  vec_cnt,  0);
    check_eq("t6_ld_ready", ld_ready, 1);
    rst_n = 1'b1;
    repeat (5) step();
    check_eq("t6_no_done", done_seen, d0);
    do_start();
    check_eq("t6_fifo_empty", busy, 0);
    $display("reset mid-run: vec_cnt=%0d sig=%08h", vec_cnt, sig);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vec_sequencer.md
VEC_SEQUENCER -- requirements
Module: vec_sequencer

Interface
REQ-001 SHALL take parameter VEC_W, default 256, the DUT input-bus width (concatenated {wire4,wire3,wire2,wire1,wire0}).
REQ-002 SHALL take parameter Y_W, default 350, the DUT output width.
REQ-003 SHALL take parameter DEPTH, default 8, the vector FIFO depth (power of 2).
REQ-004 SHALL take parameter LAT, default 1, the DUT input-to-y latency in cycles (1..4).
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-007 SHALL have ports ld_valid (input, 1), ld_ready (output, 1) and ld_data (input, VEC_W), the vector-load handshake.
REQ-008 SHALL have port start, input, 1, a one-cycle request to begin playback.
REQ-009 SHALL have port abort, input, 1, which stops playback.
REQ-010 SHALL have port busy, output, 1, which is high in RUN and DRAIN.
REQ-011 SHALL have port done, output, 1, a one-cycle completion pulse.
REQ-012 SHALL have port dut_in, output, VEC_W, the registered drive to the DUT inputs.
REQ-013 SHALL have port dut_y, input, Y_W, the DUT output.
REQ-014 SHALL have ports sig (output, 32), the MISR signature, and vec_cnt (output, 16), the count of vectors played.

Function
REQ-015 SHALL accept a load when ld_valid && ld_ready; ld_ready = !full; a push while full SHALL be impossible.
REQ-016 SHALL implement FSM states IDLE, RUN, DRAIN, DONE.
REQ-017 SHALL transition IDLE->RUN on start when the FIFO is non-empty; start while the FIFO is empty or the block is busy SHALL be ignored.
REQ-018 SHALL, on the IDLE->RUN transition, seed sig = 32'hFFFFFFFF and clear vec_cnt.
REQ-019 SHALL, in RUN, pop one entry per cycle into dut_in and increment vec_cnt (saturating at 16'hFFFF).
REQ-020 SHALL transition RUN->DRAIN in the cycle the FIFO becomes empty.
REQ-021 SHALL hold DRAIN for exactly LAT cycles, then go to DONE, then to IDLE on the next cycle; done = (state==DONE).
REQ-022 SHALL accept loads during RUN, with push and pop in the same cycle allowed and the count unchanged; a push arriving before RUN observes empty SHALL extend RUN.
REQ-023 SHALL drive dut_in = 0 in IDLE, DRAIN and DONE.
REQ-024 SHALL capture dut_y exactly LAT cycles after each vector is driven, once per played vector, using a valid shift register of length LAT.
REQ-025 SHALL fold Y_W to 32 bits by XOR of 32-bit slices of dut_y, zero-extending the final partial slice.
REQ-026 SHALL update the MISR per capture as sig <= {sig[30:0],1'b0} ^ (sig[31] ? 32'h04C11DB7 : 0) ^ fold.
REQ-027 SHALL, on abort in RUN or DRAIN, flush the FIFO, set dut_in = 0, discard pending captures and go directly to DONE; sig and vec_cnt SHALL hold.
REQ-028 SHALL give abort priority over a simultaneous start and a simultaneous load; the load is not accepted.
REQ-029 SHALL retain sig and vec_cnt after DONE until the next start.

Reset
REQ-030 SHALL, on rst_n==0 at the clock edge, set state=IDLE, FIFO empty, dut_in=0, sig=0, vec_cnt=0, done=0, busy=0, ld_ready=1, and clear the capture pipeline.
REQ-031 SHALL, when reset is asserted mid-RUN, discard all state with no done pulse.

Structure
REQ-032 SHALL place state encoding, the MISR polynomial and seed, and the default widths in package vec_seq_pkg.
REQ-033 SHALL implement the FIFO as sub-module vec_fifo (push/pop/full/empty, DEPTH entries).

Verification
REQ-034 SHALL verify: load 1 vector of all zeros with a DUT model returning y=0, then start -> dut_in=0, one capture, sig=32'hFB3EE249, vec_cnt=1, done pulses at start+1+1+LAT+1 cycles.
REQ-035 SHALL verify: load 8 vectors -> ld_ready=0 after the 8th; a 9th ld_valid is not accepted.
REQ-036 SHALL verify: start with an empty FIFO -> state stays IDLE, busy=0, no done pulse.
REQ-037 SHALL verify: a continuous load stream during RUN -> one pop per cycle with no gap, and vec_cnt equals the total number of vectors loaded.
REQ-038 SHALL verify: abort in the 3rd RUN cycle of an 8-vector run -> done next cycle, vec_cnt=3, FIFO empty, dut_in=0.
REQ-039 SHALL verify: rst_n=0 mid-RUN -> all outputs at their reset values the next cycle and no done pulse.
